// File: rtl/mc_ctrl.sv
// mc_ctrl -- multicycle MIPS-style control unit.
// Sequences FETCH/DECODE/EXEC/MEM/WB per instruction and drives the datapath
// enables, the memory handshake and a one-cycle retire pulse.
// Optional feature: define MC_CTRL_TRAP_EN to trap on illegal opcodes
// (sticky TRAP state until reset); without it illegal opcodes retire as NOPs.
module mc_ctrl (
    input  logic       CLK,
    input  logic       RST,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ack,
    output logic       mem_req,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic [1:0] RegDst,
    output logic [1:0] PCSrc,
    output logic       ALUSrc,
    output logic       MemtoReg,
    output logic       ext_zero,
    output logic [2:0] state,
    output logic       retire,
    output logic       illegal
);

    localparam logic [5:0] OP_R_FORM = 6'd0;
    localparam logic [5:0] OP_J      = 6'd2;
    localparam logic [5:0] OP_JAL    = 6'd3;
    localparam logic [5:0] OP_BEQ    = 6'd4;
    localparam logic [5:0] OP_ADDI   = 6'd8;
    localparam logic [5:0] OP_ANDI   = 6'd12;
    localparam logic [5:0] OP_ORI    = 6'd13;
    localparam logic [5:0] OP_XORI   = 6'd14;
    localparam logic [5:0] OP_LW     = 6'd35;
    localparam logic [5:0] OP_SW     = 6'd43;

    localparam logic [1:0] DST_RT  = 2'd0;
    localparam logic [1:0] DST_RD  = 2'd1;
    localparam logic [1:0] DST_R31 = 2'd2;

    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [5:0] op_q;

    // Opcode classification of the latched instruction.
    logic is_r;
    logic is_j;
    logic is_jal;
    logic is_beq;
    logic is_lw;
    logic is_sw;
    logic is_logic_imm;
    logic is_imm;
    logic is_legal;

    // Raw (ungated) control values; reset forces every output low.
    logic       mem_req_c;
    logic       mem_read_c;
    logic       mem_write_c;
    logic       ir_write_c;
    logic       pc_write_c;
    logic       reg_write_c;
    logic [1:0] reg_dst_c;
    logic [1:0] pc_src_c;
    logic       alu_src_c;
    logic       mem_to_reg_c;
    logic       retire_c;

    // Decode the latched opcode into instruction classes.
    always_comb begin
        is_r         = (op_q == OP_R_FORM);
        is_j         = (op_q == OP_J);
        is_jal       = (op_q == OP_JAL);
        is_beq       = (op_q == OP_BEQ);
        is_lw        = (op_q == OP_LW);
        is_sw        = (op_q == OP_SW);
        is_logic_imm = (op_q == OP_ANDI) || (op_q == OP_ORI) || (op_q == OP_XORI);
        is_imm       = (op_q == OP_ADDI) || is_logic_imm;
        is_legal     = is_r || is_j || is_jal || is_beq || is_lw || is_sw || is_imm;
    end

    // State register; reset discards any in-flight instruction.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Opcode latch, loaded together with the instruction register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            op_q <= OP_R_FORM;
        end else if (ir_write_c) begin
            op_q <= op;
        end
    end

    // Next-state and raw control outputs from state, op_q, zero and mem_ack.
    always_comb begin
        state_d      = state_q;
        mem_req_c    = 1'b0;
        mem_read_c   = 1'b0;
        mem_write_c  = 1'b0;
        ir_write_c   = 1'b0;
        pc_write_c   = 1'b0;
        reg_write_c  = 1'b0;
        reg_dst_c    = DST_RT;
        pc_src_c     = PC_PLUS4;
        alu_src_c    = 1'b0;
        mem_to_reg_c = 1'b0;
        retire_c     = 1'b0;

        if (!RST) begin
            case (state_q)
                ST_FETCH: begin
                    mem_req_c  = 1'b1;
                    mem_read_c = 1'b1;
                    if (mem_ack) begin
                        ir_write_c = 1'b1;
                        pc_write_c = 1'b1;
                        pc_src_c   = PC_PLUS4;
                        state_d    = ST_DECODE;
                    end
                end

                ST_DECODE: begin
                    if (is_j || is_jal) begin
                        pc_write_c = 1'b1;
                        pc_src_c   = PC_JUMP;
                        retire_c   = 1'b1;
                        if (is_jal) begin
                            reg_write_c = 1'b1;
                            reg_dst_c   = DST_R31;
                        end
                        state_d = ST_FETCH;
                    end else if (!is_legal) begin
`ifdef MC_CTRL_TRAP_EN
                        state_d = ST_TRAP;
`else
                        retire_c = 1'b1;
                        state_d  = ST_FETCH;
`endif
                    end else begin
                        state_d = ST_EXEC;
                    end
                end

                ST_EXEC: begin
                    if (is_beq) begin
                        pc_write_c = zero;
                        pc_src_c   = PC_BRANCH;
                        retire_c   = 1'b1;
                        state_d    = ST_FETCH;
                    end else if (is_lw || is_sw) begin
                        alu_src_c = 1'b1;
                        state_d   = ST_MEM;
                    end else begin
                        alu_src_c = !is_r;
                        state_d   = ST_WB;
                    end
                end

                ST_MEM: begin
                    mem_req_c   = 1'b1;
                    mem_read_c  = is_lw;
                    mem_write_c = is_sw;
                    alu_src_c   = 1'b1;
                    if (mem_ack) begin
                        if (is_sw) begin
                            retire_c = 1'b1;
                            state_d  = ST_FETCH;
                        end else begin
                            state_d = ST_WB;
                        end
                    end
                end

                ST_WB: begin
                    reg_write_c  = 1'b1;
                    reg_dst_c    = is_r ? DST_RD : DST_RT;
                    mem_to_reg_c = is_lw;
                    alu_src_c    = !is_r;
                    retire_c     = 1'b1;
                    state_d      = ST_FETCH;
                end

                ST_TRAP: begin
`ifdef MC_CTRL_TRAP_EN
                    state_d = ST_TRAP;
`else
                    state_d = ST_FETCH;
`endif
                end

                default: begin
                    state_d = ST_FETCH;
                end
            endcase
        end
    end

    // Drive the ports; reset holds every output low regardless of state.
    always_comb begin
        mem_req  = mem_req_c;
        MemRead  = mem_read_c;
        MemWrite = mem_write_c;
        IRWrite  = ir_write_c;
        PCWrite  = pc_write_c;
        RegWrite = reg_write_c;
        RegDst   = reg_dst_c;
        PCSrc    = pc_src_c;
        ALUSrc   = alu_src_c;
        MemtoReg = mem_to_reg_c;
        retire   = retire_c;
        ext_zero = !RST && is_logic_imm;
        state    = RST ? 3'd0 : state_q;
`ifdef MC_CTRL_TRAP_EN
        illegal  = !RST && (state_q == ST_TRAP);
`else
        illegal  = 1'b0;
`endif
    end

endmodule
